// File: rtl/temp_osc_pkg.sv
// Shared types and helpers for the multi-channel temperature-oscillator measurer.
// Holds the FSM encoding, the fixed phase lengths and a next-set-bit search.
package temp_osc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_STOP,
    S_CAPTURE,
    S_RESULT
  } state_t;

  localparam int STOP_CYCLES  = 2;
  localparam int CLEAR_CYCLES = 1;

  // Lowest set bit of mask strictly above idx; -1 when none. idx = -1 finds the lowest set bit.
  function automatic int next_set_above(input logic [7:0] mask, input int idx);
    int r;
    r = -1;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (i > idx)) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/temp_osc_chan_sel.sv
// Channel pointer logic: first/next enabled channel search plus one-hot oscillator controls.
// Latency: purely combinational. Backpressure: none, outputs follow the inputs directly.
module temp_osc_chan_sel
  import temp_osc_pkg::*;
#(
  parameter int NCH = 2,
  parameter int CHW = 1
) (
  input  logic [NCH-1:0] scan_mask,
  input  logic [NCH-1:0] lat_mask,
  input  logic [CHW-1:0] cur_ch,
  input  logic           pwr_en,
  input  logic           clr_en,
  output logic [CHW-1:0] first_ch,
  output logic           first_vld,
  output logic [CHW-1:0] nxt_ch,
  output logic           nxt_vld,
  output logic [NCH-1:0] pwrupOsc,
  output logic [NCH-1:0] oscCntClr
);

  int first_idx;
  int nxt_idx;

  always_comb begin
    first_idx = next_set_above(8'(scan_mask), -1);
    nxt_idx   = next_set_above(8'(lat_mask), int'(cur_ch));
    first_vld = (first_idx >= 0);
    nxt_vld   = (nxt_idx >= 0);
    first_ch  = CHW'(first_idx);
    nxt_ch    = CHW'(nxt_idx);
  end

  // pwr_en and clr_en come from mutually exclusive states, so the two vectors never overlap.
  always_comb begin
    pwrupOsc  = '0;
    oscCntClr = '0;
    for (int k = 0; k < NCH; k++) begin
      pwrupOsc[k]  = pwr_en && (int'(cur_ch) == k);
      oscCntClr[k] = clr_en && (int'(cur_ch) == k);
    end
  end

endmodule

// File: rtl/temp_osc_measure_multi.sv
// Scans NCH temperature oscillators and reports the mean of 2^AVG_LOG2 windows each; TEMP_OSC_OFFSET_EN gives offset-binary output.
// Latency: 2^AVG_LOG2*(W+4)+1 lfClk cycles per enabled channel, W = latched window length.
// Backpressure: none; res_valid is a one-cycle pulse and start is only honoured in IDLE.
module temp_osc_measure_multi
  import temp_osc_pkg::*;
#(
  parameter int  WIDTH    = 10,
  parameter int  NCH      = 2,
  parameter int  WINW     = 4,
  parameter int  AVG_LOG2 = 2,
  localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 lfClk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WINW-1:0]      win_len,
  input  logic [NCH-1:0]       ch_mask,
  input  logic [NCH*WIDTH-1:0] oscCnt,
  output logic [NCH-1:0]       oscCntClr,
  output logic [NCH-1:0]       pwrupOsc,
  output logic                 done,
  output logic                 res_valid,
  output logic [CHW-1:0]       res_ch,
  output logic [WIDTH-1:0]     cycles
);

  localparam int ACCW = WIDTH + AVG_LOG2;
  localparam int REPW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [REPW-1:0] REP_LAST = REPW'((1 << AVG_LOG2) - 1);

  state_t           state_q, state_d;
  logic [CHW-1:0]   ch_q;
  logic [NCH-1:0]   mask_q;
  logic [WINW-1:0]  win_q;
  logic [WINW-1:0]  tmr_q;
  logic [REPW-1:0]  rep_q;
  logic [ACCW-1:0]  acc_q;
  logic [ACCW-1:0]  acc_sum;
  logic [WIDTH-1:0] cnt_sel;
  logic [WIDTH-1:0] mean;
  logic [WIDTH-1:0] res_val;
  logic [CHW-1:0]   first_ch, nxt_ch;
  logic             first_vld, nxt_vld;
  logic             rep_last;

  temp_osc_chan_sel #(.NCH(NCH), .CHW(CHW)) u_chan_sel (
    .scan_mask (ch_mask),
    .lat_mask  (mask_q),
    .cur_ch    (ch_q),
    .pwr_en    (state_q == S_RUN),
    .clr_en    (state_q == S_CLEAR),
    .first_ch  (first_ch),
    .first_vld (first_vld),
    .nxt_ch    (nxt_ch),
    .nxt_vld   (nxt_vld),
    .pwrupOsc  (pwrupOsc),
    .oscCntClr (oscCntClr)
  );

  assign done     = (state_q == S_IDLE);
  assign rep_last = (rep_q == REP_LAST);
  assign cnt_sel  = oscCnt[ch_q*WIDTH +: WIDTH];
  assign acc_sum  = acc_q + ACCW'(cnt_sel);
  assign mean     = acc_sum[ACCW-1:AVG_LOG2];

`ifdef TEMP_OSC_OFFSET_EN
  assign res_val = {~mean[WIDTH-1], mean[WIDTH-2:0]};
`else
  assign res_val = mean;
`endif

  always_ff @(posedge lfClk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start && first_vld) state_d = S_CLEAR;
      S_CLEAR:   if (tmr_q == WINW'(CLEAR_CYCLES)) state_d = S_RUN;
      S_RUN:     if (tmr_q == win_q) state_d = S_STOP;
      S_STOP:    if (tmr_q == WINW'(STOP_CYCLES)) state_d = S_CAPTURE;
      S_CAPTURE: state_d = rep_last ? S_RESULT : S_CLEAR;
      S_RESULT:  state_d = nxt_vld ? S_CLEAR : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // The timer restarts at 1 on every state change, so it counts cycles spent in the current phase.
  always_ff @(posedge lfClk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q     <= '0;
      ch_q      <= '0;
      mask_q    <= '0;
      win_q     <= '0;
      rep_q     <= '0;
      acc_q     <= '0;
      res_valid <= 1'b0;
      res_ch    <= '0;
      cycles    <= '0;
    end else begin
      tmr_q     <= (state_d != state_q) ? WINW'(1) : tmr_q + WINW'(1);
      res_valid <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start && first_vld) begin
            mask_q <= ch_mask;
            win_q  <= (win_len == '0) ? WINW'(1) : win_len;
            ch_q   <= first_ch;
            rep_q  <= '0;
            acc_q  <= '0;
          end
        end
        S_CAPTURE: begin
          acc_q <= acc_sum;
          if (!rep_last) begin
            rep_q <= rep_q + REPW'(1);
          end else begin
            cycles    <= res_val;
            res_ch    <= ch_q;
            res_valid <= 1'b1;
          end
        end
        S_RESULT: begin
          acc_q <= '0;
          rep_q <= '0;
          if (nxt_vld) ch_q <= nxt_ch;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_osc_measure_multi.sv
// Scoreboard bench for temp_osc_measure_multi: directed scans push expected (channel, mean, arrival cycle); a monitor checks each res_valid.
// Also checks reset values, one-hot/overlap invariants, power-up duty and mid-scan reset behaviour.
module tb_temp_osc_measure_multi;

  localparam int WIDTH    = 10;
  localparam int NCH      = 2;
  localparam int WINW     = 4;
  localparam int AVG_LOG2 = 2;
  localparam int CHW      = 1;

`ifdef TEMP_OSC_OFFSET_EN
  localparam int T6_EXP = 768;
`else
  localparam int T6_EXP = 256;
`endif

  logic                 lfClk   = 1'b0;
  logic                 rst_n   = 1'b0;
  logic                 start   = 1'b0;
  logic [WINW-1:0]      win_len = '0;
  logic [NCH-1:0]       ch_mask = '0;
  logic [NCH*WIDTH-1:0] oscCnt;
  logic [NCH-1:0]       oscCntClr;
  logic [NCH-1:0]       pwrupOsc;
  logic                 done;
  logic                 res_valid;
  logic [CHW-1:0]       res_ch;
  logic [WIDTH-1:0]     cycles;

  typedef struct {
    int ch;
    int val;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   start_cyc = 0;
  int   done_cyc  = 0;
  int   base[NCH];
  int   step[NCH];
  int   nclr[NCH];
  int   pw_cnt[NCH];
  logic [WIDTH-1:0] cnt[NCH];

  temp_osc_measure_multi #(
    .WIDTH(WIDTH), .NCH(NCH), .WINW(WINW), .AVG_LOG2(AVG_LOG2)
  ) dut (
    .lfClk     (lfClk),
    .rst_n     (rst_n),
    .start     (start),
    .win_len   (win_len),
    .ch_mask   (ch_mask),
    .oscCnt    (oscCnt),
    .oscCntClr (oscCntClr),
    .pwrupOsc  (pwrupOsc),
    .done      (done),
    .res_valid (res_valid),
    .res_ch    (res_ch),
    .cycles    (cycles)
  );

  always #5 lfClk = ~lfClk;

  always @(posedge lfClk) cyc <= cyc + 1;

  always_comb begin
    oscCnt = '0;
    for (int k = 0; k < NCH; k++) oscCnt[k*WIDTH +: WIDTH] = cnt[k];
  end

  // Oscillator counter model: each clear request starts a window whose final count is base + step*n.
  always @(negedge lfClk) begin
    for (int k = 0; k < NCH; k++) begin
      if (oscCntClr[k]) begin
        cnt[k]  = WIDTH'(base[k] + step[k] * nclr[k]);
        nclr[k] = nclr[k] + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge lfClk) begin
    if (rst_n) begin
      chk("pwr_clr_overlap", int'(|(pwrupOsc & oscCntClr)), 0);
      chk("pwr_onehot0", int'($onehot0(pwrupOsc)), 1);
      for (int k = 0; k < NCH; k++) if (pwrupOsc[k]) pw_cnt[k]++;
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_res_valid: got pulse ch=%0d cycles=%0d at cycle %0d, required none",
                   res_ch, cycles, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("res_ch", int'(res_ch), mon_e.ch);
          chk("cycles", int'(cycles), mon_e.val);
          chk("res_cycle", cyc, mon_e.cyc);
          chk("done_low_at_result", int'(done), 0);
        end
      end
    end
  end

  task automatic set_osc(input int k, input int b, input int s);
    base[k]   = b;
    step[k]   = s;
    nclr[k]   = 0;
    pw_cnt[k] = 0;
  endtask

  task automatic issue(input logic [NCH-1:0] m, input logic [WINW-1:0] w);
    @(negedge lfClk);
    ch_mask   = m;
    win_len   = w;
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge lfClk);
    start = 1'b0;
  endtask

  task automatic push(input int ch, input int val, input int off);
    exp_q.push_back('{ch, val, start_cyc + off});
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge lfClk);
    while (!(done && exp_q.size() == 0) && n < 400) begin
      @(negedge lfClk);
      n++;
    end
    done_cyc = cyc;
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d results outstanding, done=%0d, required all delivered and done=1",
               name, exp_q.size(), done);
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NCH; k++) begin
      cnt[k] = '0;
      set_osc(k, 0, 0);
    end

    // Reset values
    #2;
    chk("rst_done", int'(done), 1);
    chk("rst_pwrup", int'(pwrupOsc), 0);
    chk("rst_clr", int'(oscCntClr), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_ch", int'(res_ch), 0);
    chk("rst_cycles", int'(cycles), 0);
    @(negedge lfClk);
    rst_n = 1'b1;

    // 1: single channel, W=1, counts 100..103 -> mean 101 after 21 cycles
    set_osc(0, 100, 1);
    set_osc(1, 0, 0);
    issue(2'b01, 4'd1);
    push(0, 101, 21);
    wait_idle("t1");
    chk("t1_pwrup0_cycles", pw_cnt[0], 4);
    chk("t1_pwrup1_cycles", pw_cnt[1], 0);
    chk("t1_clears0", nclr[0], 4);

    // 2: both channels, W=3 -> results 29 cycles apart, done rises right after the second
    set_osc(0, 200, 0);
    set_osc(1, 300, 0);
    issue(2'b11, 4'd3);
    push(0, 200, 29);
    push(1, 300, 58);
    wait_idle("t2");
    chk("t2_done_rise", done_cyc, start_cyc + 59);
    chk("t2_pwrup0_cycles", pw_cnt[0], 12);
    chk("t2_pwrup1_cycles", pw_cnt[1], 12);

    // 3a: win_len=0 behaves as 1
    set_osc(0, 0, 0);
    set_osc(1, 55, 0);
    issue(2'b10, 4'd0);
    push(1, 55, 21);
    wait_idle("t3a");
    chk("t3a_pwrup1_cycles", pw_cnt[1], 4);
    chk("t3a_pwrup0_cycles", pw_cnt[0], 0);

    // 3b: empty mask with start high does nothing
    @(negedge lfClk);
    ch_mask = '0;
    win_len = 4'd2;
    start   = 1'b1;
    repeat (8) begin
      @(negedge lfClk);
      chk("t3b_done", int'(done), 1);
      chk("t3b_pwrup", int'(pwrupOsc), 0);
      chk("t3b_clr", int'(oscCntClr), 0);
    end
    start = 1'b0;

    // 3c: start held high -> back-to-back scans with one IDLE cycle; means 18/4 and 34/4 truncate
    set_osc(0, 3, 1);
    @(negedge lfClk);
    ch_mask   = 2'b01;
    win_len   = 4'd1;
    start     = 1'b1;
    start_cyc = cyc;
    push(0, 4, 21);
    push(0, 8, 43);
    repeat (30) @(negedge lfClk);
    start = 1'b0;
    wait_idle("t3c");

    // 4: async reset during RUN of the second window, then a fresh scan
    set_osc(0, 500, 0);
    issue(2'b01, 4'd2);
    push(0, 500, 25);
    repeat (7) @(negedge lfClk);
    chk("t4_in_run", int'(pwrupOsc), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_pwrup", int'(pwrupOsc), 0);
    chk("t4_rst_clr", int'(oscCntClr), 0);
    chk("t4_rst_done", int'(done), 1);
    chk("t4_rst_cycles", int'(cycles), 0);
    chk("t4_rst_res_valid", int'(res_valid), 0);
    exp_q.delete();
    @(negedge lfClk);
    rst_n = 1'b1;
    set_osc(0, 40, 1);
    issue(2'b01, 4'd2);
    push(0, 41, 25);
    wait_idle("t4");

    // 5: config changes and a start pulse mid-scan are ignored until the next IDLE start
    set_osc(0, 10, 2);
    set_osc(1, 999, 0);
    issue(2'b01, 4'd1);
    push(0, 13, 21);
    repeat (3) @(negedge lfClk);
    ch_mask = 2'b11;
    win_len = 4'd7;
    start   = 1'b1;
    @(negedge lfClk);
    start = 1'b0;
    wait_idle("t5a");
    chk("t5a_pwrup1_cycles", pw_cnt[1], 0);
    set_osc(0, 7, 0);
    set_osc(1, 1000, 0);
    @(negedge lfClk);
    start     = 1'b1;
    start_cyc = cyc;
    push(0, 7, 45);
    push(1, 1000, 90);
    @(negedge lfClk);
    start = 1'b0;
    wait_idle("t5b");
    chk("t5b_pwrup1_cycles", pw_cnt[1], 28);

    // 6: mid-scale count 0x100 (0x300 in offset-binary builds)
    set_osc(0, 256, 0);
    set_osc(1, 0, 0);
    issue(2'b01, 4'd1);
    push(0, T6_EXP, 21);
    wait_idle("t6");

    repeat (3) @(negedge lfClk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/temp_osc_measure_multi.md
Name: temp_osc_measure_multi

Overview:
- Multi-channel, averaging successor to the single-shot temperature-oscillator measurer.
- Runs in the lfClk (32.768 kHz) domain and sequences NCH analog temperature oscillators one at a time: clear counter, power up for a programmable window, power down, capture.
- Each oscillator's cycle count comes from an external per-channel counter clocked by that oscillator. The counter is frozen (osc stopped) before sampling, so no multi-bit CDC issue arises.
- Repeats 2^AVG_LOG2 windows per channel and outputs the truncated mean per channel.

Parameters:
- WIDTH, 10, counter/result width in bits.
- NCH, 2, number of oscillator channels (1..8).
- WINW, 4, width of the window-length field.
- AVG_LOG2, 2, log2 of windows averaged per channel (0 = single shot).

Ports:
- lfClk  in  1  32.768 kHz clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level sampled in IDLE; begins a scan.
- win_len  in  WINW  window length in lfClk periods; 0 is treated as 1; sampled at scan start.
- ch_mask  in  NCH  channels enabled for the scan; sampled at scan start.
- oscCnt  in  NCH*WIDTH  binary count per channel, ch k at [k*WIDTH +: WIDTH]; stable once osc stopped.
- oscCntClr  out  NCH  synchronous clear request to the selected channel's counter.
- pwrupOsc  out  NCH  one-hot power-up of the selected oscillator.
- done  out  1  high in IDLE, low while a scan runs.
- res_valid  out  1  one-cycle pulse when cycles/res_ch update.
- res_ch  out  $clog2(NCH) (min 1)  channel of the current result.
- cycles  out  WIDTH  averaged count for res_ch.

Behaviour:
- Reset (asynchronous, applies at any time including mid-scan):
  - state IDLE, pwrupOsc 0, oscCntClr 0, done 1, res_valid 0, res_ch 0, cycles 0.
  - Accumulator, repeat counter and latched config are cleared.
- FSM states: IDLE, CLEAR, RUN, STOP, CAPTURE, RESULT.
- IDLE:
  - If start=1 and ch_mask≠0: latch win_len (0→1) and ch_mask, select the lowest set channel, go to CLEAR. done drops in the CLEAR cycle.
  - If start=1 and ch_mask=0: stay in IDLE, done stays 1, no outputs toggle.
- CLEAR (1 cycle): oscCntClr[ch]=1, pwrupOsc=0.
- RUN (W cycles, W = latched window length): pwrupOsc[ch]=1, oscCntClr=0.
- STOP (2 cycles): pwrupOsc=0; the oscillator halts and the count settles.
- CAPTURE (1 cycle):
  - acc += oscCnt[ch]; acc is WIDTH+AVG_LOG2 bits wide and cannot overflow.
  - If rep < 2^AVG_LOG2−1: rep++, go to CLEAR. Otherwise go to RESULT.
- RESULT (1 cycle):
  - cycles ← acc[WIDTH+AVG_LOG2-1:AVG_LOG2] (truncating mean); res_ch ← ch; res_valid=1.
  - Clear acc and rep. Go to the next higher set bit of the latched mask via CLEAR; if none remain, go to IDLE.
- Per-window latency: W+4 cycles. Per-channel latency: 2^AVG_LOG2·(W+4)+1 cycles.
- Outputs in the scan body:
  - done=0 from CLEAR through RESULT.
  - done=1 again in the first IDLE cycle; no one-cycle dip between channels.
- Concurrency and hold rules:
  - start, win_len and ch_mask are ignored while not in IDLE.
  - A start held high after completion begins a new scan immediately; one IDLE cycle exists between scans.
  - cycles and res_ch hold their last value until the next RESULT.
- Invariants:
  - pwrupOsc and oscCntClr are never high together.
  - At most one pwrupOsc bit is high at any time.

Optional Feature:
- Macro: TEMP_OSC_OFFSET_EN.
- Defined: RESULT writes cycles with the MSB inverted (offset-binary around mid-scale), consistent with existing temperature outputs.
- Undefined: cycles is the plain binary mean.
- The accumulator is unaffected either way.

Decomposition:
- Package temp_osc_pkg holds:
  - the state enum typedef (6 states, 3 bits);
  - STOP_CYCLES=2 and CLEAR_CYCLES=1 localparams;
  - a function returning the next set bit above a given index in a mask.
- One sub-module, temp_osc_chan_sel: priority next-channel pointer plus one-hot decode for pwrupOsc/oscCntClr.
- Remaining logic (FSM, window timer, accumulator) stays in the top.

Test Plan:
1. NCH=2, AVG_LOG2=2, win_len=1, ch_mask=01, oscCnt[0] model returns 100,101,102,103 → one res_valid 21 cycles after start, cycles=101, res_ch=0, pwrupOsc[0] high exactly 1 cycle per window.
2. ch_mask=11, win_len=3, constant counts 200 / 300 → res_valid pulses 29 cycles apart, (ch0, 200) then (ch1, 300); done low throughout, high 1 cycle after the second pulse.
3. win_len=0 → RUN lasts 1 cycle (same timing as win_len=1); ch_mask=0 with start=1 → no activity, done=1.
4. Assert rst_n low during RUN of the second window → pwrupOsc=0, done=1, cycles=0 immediately (async); the next scan averages only fresh windows.
5. Change win_len/ch_mask and pulse start mid-scan → no effect on the current scan; the new values apply only at the next IDLE start.
6. With TEMP_OSC_OFFSET_EN, count 0x100 (WIDTH=10) → cycles=0x300; without the macro → cycles=0x100.
